// File: rtl/pattern_stream_generator_if.sv
// Pixel stream bundle between the pattern generator (master) and the ISP core input (slave).
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; once out_valid is
// raised the master holds every stream field stable until that transfer happens.
interface pattern_stream_generator_if #(
  parameter int PIXEL_BIT_SIZE = 8,
  parameter int X_BIT_SIZE     = 6,
  parameter int Y_BIT_SIZE     = 6
);
  logic                      out_valid;
  logic                      out_ready;
  logic [PIXEL_BIT_SIZE-1:0] out_pixel;
  logic [X_BIT_SIZE-1:0]     out_x;
  logic [Y_BIT_SIZE-1:0]     out_y;
  logic                      out_sof;
  logic                      out_eol;

  modport master (
    output out_valid, out_pixel, out_x, out_y, out_sof, out_eol,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pixel, out_x, out_y, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/pattern_stream_generator.sv
// Raster pattern source for the optical-flow ISP input: solid, ramps, checker and shifted variants.
// Optional macro PATTERN_NOISE_EN adds 2-bit LFSR noise (saturating) to every pixel.
module pattern_stream_generator #(
  parameter int IMAGE_WIDTH        = 64,
  parameter int IMAGE_HEIGHT       = 48,
  parameter int PIXEL_BIT_SIZE     = 8,
  parameter int CHECKER_LOG2       = 3,
  parameter int FRAME_CNT_BIT_SIZE = 16,
  parameter int X_BIT_SIZE         = $clog2(IMAGE_WIDTH),
  parameter int Y_BIT_SIZE         = $clog2(IMAGE_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [2:0]                    mode,
  input  logic [FRAME_CNT_BIT_SIZE-1:0] num_frames,
  input  logic [7:0]                    shift_x,
  input  logic [PIXEL_BIT_SIZE-1:0]     solid_value,
  pattern_stream_generator_if.master    stream,
  output logic [FRAME_CNT_BIT_SIZE-1:0] frame_idx,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state_o
);

  localparam int XW  = X_BIT_SIZE;
  localparam int YW  = Y_BIT_SIZE;
  localparam int P   = PIXEL_BIT_SIZE;
  localparam int FW  = FRAME_CNT_BIT_SIZE;
  localparam int XW1 = XW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW:0]   W_EXT  = XW1'(IMAGE_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q;
  logic [2:0]     mode_q;
  logic [P-1:0]   solid_q;
  logic [FW-1:0]  num_q;
  logic [FW-1:0]  frame_q;
  logic [XW-1:0]  shift_mod_q;
  logic [XW-1:0]  off_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           valid_q;
  logic [P-1:0]   pixel_q;
  logic           sof_q;
  logic           eol_q;
  logic           busy_q;
  logic           done_q;

  logic [2:0]     mode_sel;
  logic [P-1:0]   solid_sel;
  logic           last_x;
  logic           last_y;
  logic           frame_end;
  logic           last_frame;
  logic           xfer;
  logic [XW:0]    off_sum;
  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;
  logic [XW-1:0]  off_d;
  logic [P-1:0]   pat_d;
  logic [P-1:0]   pixel_d;

  function automatic logic checker_bit(input logic [XW-1:0] cx, input logic [YW-1:0] cy);
    logic bx;
    logic by;
    bx = ((cx >> CHECKER_LOG2) & XW'(1)) != '0;
    by = ((cy >> CHECKER_LOG2) & YW'(1)) != '0;
    return bx ^ by;
  endfunction

  function automatic logic [P-1:0] pattern_pixel(
    input logic [2:0]    m,
    input logic [P-1:0]  solid,
    input logic [XW-1:0] px,
    input logic [YW-1:0] py,
    input logic [XW-1:0] off
  );
    logic [XW:0]   xsum;
    logic [XW-1:0] xs;
    logic [P-1:0]  r;
    // off < IMAGE_WIDTH and px < IMAGE_WIDTH, so a single conditional subtract is the modulo
    xsum = {1'b0, px} + {1'b0, off};
    if (xsum >= W_EXT) xsum = xsum - W_EXT;
    xs = xsum[XW-1:0];
    case (m)
      3'd1:    r = P'(px);
      3'd2:    r = P'(py);
      3'd3:    r = checker_bit(px, py) ? '1 : '0;
      3'd4:    r = P'(xs);
      3'd5:    r = checker_bit(xs, py) ? '1 : '0;
      default: r = solid;
    endcase
    return r;
  endfunction

  // Next beat position and pixel; in IDLE this is pixel (0,0) of a fresh run using the live inputs.
  always_comb begin
    mode_sel   = (state_q == IDLE) ? mode : mode_q;
    solid_sel  = (state_q == IDLE) ? solid_value : solid_q;
    last_x     = (x_q == X_LAST);
    last_y     = (y_q == Y_LAST);
    frame_end  = last_x && last_y;
    last_frame = (frame_q == num_q - FW'(1));
    xfer       = valid_q && stream.out_ready;
    off_sum    = {1'b0, off_q} + {1'b0, shift_mod_q};
    if (off_sum >= W_EXT) off_sum = off_sum - W_EXT;
    x_d   = last_x ? '0 : x_q + XW'(1);
    y_d   = last_x ? (last_y ? '0 : y_q + YW'(1)) : y_q;
    off_d = frame_end ? off_sum[XW-1:0] : off_q;
    if (state_q == IDLE) begin
      x_d   = '0;
      y_d   = '0;
      off_d = '0;
    end
    pat_d = pattern_pixel(mode_sel, solid_sel, x_d, y_d, off_d);
  end

`ifdef PATTERN_NOISE_EN
  localparam int PW1 = P + 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [P:0]  noisy;

  always_comb begin
    lfsr_d  = (state_q == IDLE) ? LFSR_SEED
                                : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    noisy   = {1'b0, pat_d} + PW1'(lfsr_d[1:0]);
    pixel_d = noisy[P] ? '1 : noisy[P-1:0];
  end

  // Reseeds on start and steps once per accepted pixel, so lfsr_d always belongs to the next beat.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else if ((state_q == IDLE && start) || (state_q == RUN && xfer)) lfsr_q <= lfsr_d;
  end
`else
  assign pixel_d = pat_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      solid_q     <= '0;
      num_q       <= '0;
      frame_q     <= '0;
      shift_mod_q <= '0;
      off_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      pixel_q     <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q      <= mode;
            solid_q     <= solid_value;
            num_q       <= num_frames;
            shift_mod_q <= XW'(32'(shift_x) % 32'(IMAGE_WIDTH));
            frame_q     <= '0;
            off_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            if (num_frames == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              valid_q <= 1'b1;
              pixel_q <= pixel_d;
              sof_q   <= 1'b1;
              eol_q   <= (X_LAST == '0);
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (frame_end && last_frame) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sof_q   <= 1'b0;
              eol_q   <= 1'b0;
              x_q     <= '0;
              y_q     <= '0;
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              off_q   <= off_d;
              if (frame_end) frame_q <= frame_q + FW'(1);
              pixel_q <= pixel_d;
              sof_q   <= (x_d == '0) && (y_d == '0);
              eol_q   <= (x_d == X_LAST);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_pixel = pixel_q;
  assign stream.out_x     = x_q;
  assign stream.out_y     = y_q;
  assign stream.out_sof   = sof_q;
  assign stream.out_eol   = eol_q;
  assign frame_idx        = frame_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dbg_state_o      = state_q;

endmodule
